// File: rtl/traffic_pkg.sv
// Shared types and encodings for the intersection light controller.
// The WALK state exists only when TRAFFIC_PED_WALK_EN is defined.
package traffic_pkg;

   typedef enum logic [2:0] {
      ALL_RED_B = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALL_RED_A = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
`ifdef TRAFFIC_PED_WALK_EN
      WALK      = 3'd6,
`endif
      FAULT     = 3'd7
   } state_t;

   localparam logic [2:0] SEL_GREEN  = 3'b001;
   localparam logic [2:0] SEL_YELLOW = 3'b010;
   localparam logic [2:0] SEL_RED    = 3'b100;
   localparam logic [2:0] SEL_IDLE   = 3'b000;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   function automatic logic [2:0] sel_of(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN:   sel_of = SEL_GREEN;
         NS_YELLOW, EW_YELLOW: sel_of = SEL_YELLOW;
         FAULT:                sel_of = SEL_IDLE;
         default:              sel_of = SEL_RED;
      endcase
   endfunction

endpackage

// File: rtl/traffic_watchdog.sv
// Advance-timeout counter plus the flash divider used once the timeout trips.
module traffic_watchdog #(
   parameter int WDOG_CYCLES = 16,
   parameter int FLASH_DIV   = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_advance,
   output logic o_expired,
   output logic o_flash
);

   localparam int CW = $clog2(WDOG_CYCLES);
   localparam int DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_div;
   logic          r_tripped;
   logic          r_flash;
   logic          w_max;

   assign w_max     = (r_cnt == CW'(WDOG_CYCLES - 1));
   assign o_expired = w_max;
   assign o_flash   = r_flash;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_div     <= '0;
         r_tripped <= 1'b0;
         r_flash   <= 1'b0;
      end else begin
         if (i_advance)  r_cnt <= '0;
         else if (!w_max) r_cnt <= r_cnt + 1'b1;
         // Flash starts lit on the trip edge, then toggles every FLASH_DIV cycles.
         if (!r_tripped) begin
            if (w_max) begin
               r_tripped <= 1'b1;
               r_flash   <= 1'b1;
               r_div     <= '0;
            end
         end else if (r_div == DW'(FLASH_DIV - 1)) begin
            r_div   <= '0;
            r_flash <= ~r_flash;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_controller.sv
// Two-road light phase sequencer with watchdog fault mode.
// Optional pedestrian WALK phase enabled by TRAFFIC_PED_WALK_EN.
module traffic_controller import traffic_pkg::*; #(
   parameter int WDOG_CYCLES = 16,
   parameter int FLASH_DIV   = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_max_reached,
   input  logic       i_ped_req,
   output logic [2:0] o_select,
   output logic [2:0] o_ns_light,
   output logic [2:0] o_ew_light,
   output logic       o_walk,
   output logic       o_fault
);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_sel;
   logic       r_walk;
   logic       r_fault;
   logic       r_armed;
   logic       w_advance;
   logic       w_expired;
   logic       w_flash;
   logic [2:0] w_ns;
   logic [2:0] w_ew;

`ifdef TRAFFIC_PED_WALK_EN
   logic r_ped;
`else
   logic w_unused_ped;
   assign w_unused_ped = i_ped_req;
`endif

   // Armed gating makes a held-high max_reached count as a single advance.
   assign w_advance = i_max_reached & r_armed & (r_state != FAULT);

   traffic_watchdog #(.WDOG_CYCLES(WDOG_CYCLES), .FLASH_DIV(FLASH_DIV)) u_wdog (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_advance (w_advance),
      .o_expired (w_expired),
      .o_flash   (w_flash)
   );

   always_comb begin
      w_next = r_state;
      if (r_state != FAULT) begin
         if (w_expired) begin
            w_next = FAULT;
         end else if (w_advance) begin
            case (r_state)
`ifdef TRAFFIC_PED_WALK_EN
               ALL_RED_B: w_next = (r_ped | i_ped_req) ? WALK : NS_GREEN;
               WALK:      w_next = NS_GREEN;
`else
               ALL_RED_B: w_next = NS_GREEN;
`endif
               NS_GREEN:  w_next = NS_YELLOW;
               NS_YELLOW: w_next = ALL_RED_A;
               ALL_RED_A: w_next = EW_GREEN;
               EW_GREEN:  w_next = EW_YELLOW;
               EW_YELLOW: w_next = ALL_RED_B;
               default:   w_next = r_state;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ALL_RED_B;
         r_sel   <= SEL_RED;
         r_walk  <= 1'b0;
         r_fault <= 1'b0;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_next;
         r_sel   <= sel_of(w_next);
         r_fault <= (w_next == FAULT);
`ifdef TRAFFIC_PED_WALK_EN
         r_walk  <= (w_next == WALK);
`else
         r_walk  <= 1'b0;
`endif
         if (w_advance)           r_armed <= 1'b0;
         else if (!i_max_reached) r_armed <= 1'b1;
      end
   end

`ifdef TRAFFIC_PED_WALK_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                      r_ped <= 1'b0;
      else if (w_next == WALK && r_state != WALK)     r_ped <= 1'b0;
      else if (r_state != FAULT && i_ped_req)         r_ped <= 1'b1;
   end
`endif

   always_comb begin
      w_ns = LAMP_R;
      w_ew = LAMP_R;
      case (r_state)
         NS_GREEN:  w_ns = LAMP_G;
         NS_YELLOW: w_ns = LAMP_Y;
         EW_GREEN:  w_ew = LAMP_G;
         EW_YELLOW: w_ew = LAMP_Y;
         FAULT: begin
            w_ns = w_flash ? LAMP_Y : LAMP_OFF;
            w_ew = w_flash ? LAMP_Y : LAMP_OFF;
         end
         default: ;
      endcase
   end

   assign o_select   = r_sel;
   assign o_ns_light = w_ns;
   assign o_ew_light = w_ew;
   assign o_walk     = r_walk;
   assign o_fault    = r_fault;

endmodule

// File: tb/tb_traffic_controller.sv
// Directed, table-driven bench for traffic_controller; expectations follow
// TRAFFIC_PED_WALK_EN when it is defined for the build.
module tb_traffic_controller;

   // {select, ns, ew, walk, fault}
   typedef logic [10:0] exp_t;
   typedef struct {
      logic mr;
      logic ped;
      exp_t e;
   } vec_t;

   localparam exp_t E_ARB = {3'b100, 3'b100, 3'b100, 1'b0, 1'b0};
   localparam exp_t E_NSG = {3'b001, 3'b001, 3'b100, 1'b0, 1'b0};
   localparam exp_t E_NSY = {3'b010, 3'b010, 3'b100, 1'b0, 1'b0};
   localparam exp_t E_ARA = {3'b100, 3'b100, 3'b100, 1'b0, 1'b0};
   localparam exp_t E_EWG = {3'b001, 3'b100, 3'b001, 1'b0, 1'b0};
   localparam exp_t E_EWY = {3'b010, 3'b100, 3'b010, 1'b0, 1'b0};
`ifdef TRAFFIC_PED_WALK_EN
   localparam exp_t E_WALK = {3'b100, 3'b100, 3'b100, 1'b1, 1'b0};
`endif

   logic       clk, rst, mr, ped, clk_run;
   logic [2:0] sel, ns, ew;
   logic       walk, fault;
   int         checks, errors;

   traffic_controller #(.WDOG_CYCLES(16), .FLASH_DIV(4)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_max_reached (mr),
      .i_ped_req     (ped),
      .o_select      (sel),
      .o_ns_light    (ns),
      .o_ew_light    (ew),
      .o_walk        (walk),
      .o_fault       (fault)
   );

   always #5 if (clk_run) clk = ~clk;

   task automatic check(input string nm, input exp_t e);
      exp_t got;
      got = {sel, ns, ew, walk, fault};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s got sel=%b ns=%b ew=%b walk=%b fault=%b expected sel=%b ns=%b ew=%b walk=%b fault=%b",
                  nm, sel, ns, ew, walk, fault, e[10:8], e[7:5], e[4:2], e[1], e[0]);
      end
   endtask

   task automatic step(input logic m, input logic p, input exp_t e, input string nm);
      mr  = m;
      ped = p;
      @(posedge clk);
      #1;
      check(nm, e);
   endtask

   task automatic pulse(input exp_t e, input string nm);
      step(1'b1, 1'b0, e, nm);
      step(1'b0, 1'b0, e, {nm, "_hold"});
   endtask

   task automatic async_reset(input string nm);
      rst = 1'b1;
      #1;
      check(nm, E_ARB);
      rst = 1'b0;
   endtask

   vec_t q[$];
   exp_t ph[6];
   exp_t fe;
   logic f;

   initial begin
      clk = 0; rst = 0; mr = 0; ped = 0; clk_run = 0;
      checks = 0; errors = 0;

      // Full cycle: pulses every 5 cycles, then the held-pulse sequence.
      ph[0] = E_NSG; ph[1] = E_NSY; ph[2] = E_ARA;
      ph[3] = E_EWG; ph[4] = E_EWY; ph[5] = E_ARB;
      for (int i = 0; i < 6; i++) begin
         q.push_back('{1'b1, 1'b0, ph[i]});
         for (int k = 0; k < 4; k++) q.push_back('{1'b0, 1'b0, ph[i]});
      end
      q.push_back('{1'b1, 1'b0, E_NSG});
      q.push_back('{1'b0, 1'b0, E_NSG});
      for (int k = 0; k < 4; k++) q.push_back('{1'b1, 1'b0, E_NSY});
      q.push_back('{1'b0, 1'b0, E_NSY});
      q.push_back('{1'b1, 1'b0, E_ARA});
      q.push_back('{1'b0, 1'b0, E_ARA});

      // Asynchronous reset with the clock stopped.
      #3 rst = 1'b1;
      #1 check("reset_no_clock", E_ARB);
      #2 rst = 1'b0;
      clk_run = 1'b1;

      foreach (q[i]) step(q[i].mr, q[i].ped, q[i].e, $sformatf("vec%0d", i));

      // Watchdog: 15 idle edges stay normal, the 16th trips even with a pulse.
      async_reset("reset_pre_wdog");
      for (int i = 1; i <= 15; i++) step(1'b0, 1'b0, E_ARB, $sformatf("wdog_idle%0d", i));
      for (int j = 0; j < 12; j++) begin
         f  = ((j / 4) % 2) == 0;
         fe = {3'b000, 1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0, 1'b1};
         step(~j[0], j[1], fe, $sformatf("fault%0d", j));
      end
      async_reset("reset_from_fault");
      step(1'b1, 1'b0, E_NSG, "recover_nsg");

      // Pedestrian request during EW_GREEN.
      async_reset("reset_pre_ped");
      pulse(E_NSG, "p_nsg");
      pulse(E_NSY, "p_nsy");
      pulse(E_ARA, "p_ara");
      step(1'b1, 1'b0, E_EWG, "p_ewg");
      step(1'b0, 1'b1, E_EWG, "p_ewg_req");
      step(1'b0, 1'b0, E_EWG, "p_ewg_after");
      pulse(E_EWY, "p_ewy");
      pulse(E_ARB, "p_arb");
`ifdef TRAFFIC_PED_WALK_EN
      pulse(E_WALK, "p_walk");
`endif
      pulse(E_NSG, "p_nsg2");
      pulse(E_NSY, "p2_nsy");
      pulse(E_ARA, "p2_ara");
      pulse(E_EWG, "p2_ewg");
      pulse(E_EWY, "p2_ewy");
      pulse(E_ARB, "p2_arb");
      pulse(E_NSG, "p2_skip_walk");

      // Reset in EW_YELLOW with a pending request must drop the request.
      async_reset("reset_pre_mid");
      pulse(E_NSG, "m_nsg");
      pulse(E_NSY, "m_nsy");
      pulse(E_ARA, "m_ara");
      pulse(E_EWG, "m_ewg");
      pulse(E_EWY, "m_ewy");
      step(1'b0, 1'b1, E_EWY, "m_ewy_req");
      async_reset("reset_mid_op");
      step(1'b0, 1'b0, E_ARB, "m_arb_idle");
      step(1'b1, 1'b0, E_NSG, "m_no_walk");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_controller.md
# traffic_controller

Phase sequencer for the two-road intersection light. It drives the one-hot `select` phase code into the phase timer and consumes the timer's `maxReached` end-of-phase pulse to step through the light sequence. It decodes the current phase into north-south and east-west lamp outputs. It also runs a watchdog that drops into a flashing-yellow fault mode if the timer stops responding.

## Interface
- `WDOG_CYCLES`, default 16: cycles without an accepted advance before entering FAULT; must exceed the longest phase (green, 6 cycles).
- `FLASH_DIV`, default 4: FAULT yellow toggle period, in cycles.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `max_reached`, input, 1: end-of-phase pulse from the phase timer.
- `ped_req`, input, 1: pedestrian request; level or pulse, sampled every cycle.
- `select`, output, 3: phase code to the timer, one-hot: 001 green (6 cycles), 010 yellow (3 cycles), 100 red (5 cycles).
- `ns_light`, output, 3: north-south lamps, encoded {R,Y,G}.
- `ew_light`, output, 3: east-west lamps, encoded {R,Y,G}.
- `walk`, output, 1: pedestrian walk lamp.
- `fault`, output, 1: watchdog fault indicator.

## Operation
- **States:** ALL_RED_B, NS_GREEN, NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, WALK (macro only), FAULT.
- **Sequence:** ALL_RED_B → NS_GREEN → NS_YELLOW → ALL_RED_A → EW_GREEN → EW_YELLOW → ALL_RED_B.
- **State decode:**
  - NS_GREEN: select 001, ns 001, ew 100.
  - NS_YELLOW: select 010, ns 010, ew 100.
  - EW_GREEN: select 001, ns 100, ew 001.
  - EW_YELLOW: select 010, ns 100, ew 010.
  - ALL_RED_A / ALL_RED_B: select 100, ns 100, ew 100.
  - WALK: select 100, ns 100, ew 100, walk 1.
  - FAULT: select 000, R=G=0 on both roads, Y = flash bit, fault 1.
- **Advance rule:** advance = `max_reached` high AND armed bit set.
  - Armed clears on each advance.
  - Armed re-sets on any cycle where `max_reached` is sampled low.
  - Consequence: a held-high `max_reached` produces exactly one advance.
- **Watchdog:**
  - Counter clears on every advance and increments otherwise.
  - When it reaches `WDOG_CYCLES` − 1 with no advance, the next state is FAULT.
- **FAULT:**
  - Absorbing; left only by `rst`.
  - `max_reached` and `ped_req` are ignored.
  - Flash bit is 1 on entry and toggles every `FLASH_DIV` cycles.
- **Simultaneous events:** watchdog expiry in the same cycle as an advance → FAULT wins.

## Timing
- All outputs are a pure decode of registered state (Moore); no combinational input-to-output path.
- Advance sampled at edge k → new state, `select` and lamps valid immediately after edge k (1-cycle latency).
- `select` changes only on advance, FAULT entry, or reset. It is never 000 outside FAULT and never multi-hot.
- **Reset** (asynchronous, takes effect without a clock edge):
  - Outputs: state ALL_RED_B, select 100, ns 100, ew 100, walk 0, fault 0.
  - Internal: watchdog 0, armed 1, ped latch 0, flash bit 0.
- Reset mid-phase, including mid-FAULT, behaves identically to power-up reset.
- Watchdog counter width is `$clog2(WDOG_CYCLES)`; it saturates and never wraps.

## Configuration
- Macro: `TRAFFIC_PED_WALK_EN`.
- **With the macro defined:**
  - `ped_req` sets a sticky latch in any non-FAULT state.
  - On advance out of ALL_RED_B, if (latch OR `ped_req`) the next state is WALK; otherwise NS_GREEN.
  - Entering WALK clears the latch.
  - WALK advances to NS_GREEN.
- **Without the macro:** WALK state and latch are absent, `ped_req` is ignored, `walk` is tied 0.

## Structure
- Package `traffic_pkg`:
  - State enum.
  - Select constants `SEL_GREEN`=001, `SEL_YELLOW`=010, `SEL_RED`=100, `SEL_IDLE`=000.
  - Lamp constants `LAMP_R`=100, `LAMP_Y`=010, `LAMP_G`=001, `LAMP_OFF`=000.
- Sub-module `traffic_watchdog`:
  - Inputs: clk, rst, advance.
  - Contains the timeout counter and flash divider.
  - Outputs: `expired`, `flash`.

## Test plan
- **Reset:** assert `rst` with no clock running → select=100, ns=ew=100, fault=0, walk=0 immediately. Release `rst`, pulse `max_reached` for 1 cycle → next cycle select=001, ns=001, ew=100.
- **Full cycle:** 6 single-cycle pulses spaced 5 cycles apart → select sequence 001, 010, 100, 001, 010, 100; lamps match the decode table; ends in ALL_RED_B.
- **Held pulse:** `max_reached` held high 4 cycles in NS_GREEN → exactly one advance, to NS_YELLOW. Drop low for 1 cycle, pulse again → ALL_RED_A.
- **Watchdog:** no pulse for 16 cycles → fault=1, select=000, both lamps 010/000 alternating every 4 cycles. Further pulses cause no change until `rst`.
- **Pedestrian (macro on):** 1-cycle `ped_req` during EW_GREEN → after the ALL_RED_B advance, walk=1 and select=100. Next pulse → NS_GREEN, walk=0. A second pass without a request skips WALK. With the macro off, the same stimulus goes straight to NS_GREEN.
- **Reset mid-operation:** `rst` pulsed in EW_YELLOW with the ped latch set → ALL_RED_B outputs, latch cleared; the next advance goes to NS_GREEN, not WALK.
